// File: rtl/sap2_pkg.sv
// Shared SAP-2 definitions: multi-byte opcode constants, fetch state encoding,
// and the raw 8080 length decode used by the fetch register and the sequencer.
package sap2_pkg;

  localparam logic [7:0] OP_MVI_A = 8'h3E;
  localparam logic [7:0] OP_MVI_B = 8'h06;
  localparam logic [7:0] OP_MVI_C = 8'h0E;
  localparam logic [7:0] OP_ANI   = 8'hE6;
  localparam logic [7:0] OP_XRI   = 8'hEE;
  localparam logic [7:0] OP_ORI   = 8'hF6;
  localparam logic [7:0] OP_IN    = 8'hDB;
  localparam logic [7:0] OP_OUT   = 8'hD3;

  localparam logic [7:0] OP_LDA   = 8'h3A;
  localparam logic [7:0] OP_STA   = 8'h32;
  localparam logic [7:0] OP_JMP   = 8'hC3;
  localparam logic [7:0] OP_JNZ   = 8'hC2;
  localparam logic [7:0] OP_JZ    = 8'hCA;
  localparam logic [7:0] OP_JM    = 8'hFA;
  localparam logic [7:0] OP_CALL  = 8'hCD;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FETCH    = 2'd1,
    COMPLETE = 2'd2
  } fetch_state_e;

  // Unclamped instruction length in bytes (1..3) for an 8080-encoded opcode.
  function automatic int unsigned raw_instr_len(input logic [7:0] op);
    case (op)
      OP_MVI_A, OP_MVI_B, OP_MVI_C,
      OP_ANI, OP_XRI, OP_ORI,
      OP_IN, OP_OUT:                    return 2;
      OP_LDA, OP_STA,
      OP_JMP, OP_JNZ, OP_JZ, OP_JM,
      OP_CALL:                          return 3;
      default:                          return 1;
    endcase
  endfunction

endpackage

// File: rtl/instr_length_decoder.sv
// Combinational opcode-to-length decode, clamped to MAX_BYTES.
// Only the low 8 bits of the opcode take part in the decode.
module instr_length_decoder
  import sap2_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 3,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic [DATA_W-1:0] i_opcode,
  output logic [LEN_W-1:0]  o_len
);

  logic [7:0]  w_op8;
  int unsigned w_raw_len;
  int unsigned w_clamped_len;

  assign w_op8 = 8'(i_opcode);

  always_comb begin
    w_raw_len     = raw_instr_len(w_op8);
    w_clamped_len = w_raw_len;
    if (w_raw_len > MAX_BYTES) begin
      w_clamped_len = MAX_BYTES;
    end
    o_len = LEN_W'(w_clamped_len);
  end

endmodule

// File: rtl/instr_fetch_register.sv
// Multi-byte instruction register: captures an opcode from WBUS, gathers its
// operand bytes, and holds the complete instruction until the sequencer acks.
module instr_fetch_register
  import sap2_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int MAX_BYTES  = 3,
  parameter  int LEN_W      = $clog2(MAX_BYTES + 1),
  localparam int OPND_SLOTS = (MAX_BYTES > 1) ? (MAX_BYTES - 1) : 1,
  localparam int OPND_W     = OPND_SLOTS * DATA_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [DATA_W-1:0] WBUS,
  input  logic              nLi,
  input  logic              nACK,
  input  logic              nFLUSH,
  output logic [DATA_W-1:0] opcode,
  output logic [OPND_W-1:0] operand,
  output logic [LEN_W-1:0]  instr_len,
  output logic [LEN_W-1:0]  byte_cnt,
  output logic              ready,
  output logic              ovr
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nx;
  logic [DATA_W-1:0] r_opcode;
  logic [OPND_W-1:0] r_operand;
  logic [LEN_W-1:0]  r_instr_len;
  logic [LEN_W-1:0]  r_byte_cnt;
  logic              r_ready;
  logic              r_ovr;

  logic [LEN_W-1:0]  w_dec_len;
  logic              w_load_opcode;
  logic              w_load_operand;
  logic              w_release;
  logic              w_overrun;
  logic              w_last_operand;

  instr_length_decoder #(
    .DATA_W    (DATA_W),
    .MAX_BYTES (MAX_BYTES),
    .LEN_W     (LEN_W)
  ) u_len_dec (
    .i_opcode (WBUS),
    .o_len    (w_dec_len)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Acking in COMPLETE while a byte is offered starts the next instruction
  // on the same edge, so the new byte is always an opcode there.
  always_comb begin
    w_load_opcode  = 1'b0;
    w_load_operand = 1'b0;
    w_release      = 1'b0;
    w_overrun      = 1'b0;
    w_last_operand = ((r_byte_cnt + LEN_W'(1)) == r_instr_len);
    w_state_nx     = r_state;

    case (r_state)
      EMPTY: begin
        w_load_opcode = !nLi;
      end
      FETCH: begin
        w_load_operand = !nLi;
      end
      COMPLETE: begin
        w_load_opcode = !nLi && !nACK;
        w_release     = nLi && !nACK;
        w_overrun     = !nLi && nACK;
      end
      default: begin
        w_state_nx = EMPTY;
      end
    endcase

    if (w_load_opcode) begin
      w_state_nx = (w_dec_len == LEN_W'(1)) ? COMPLETE : FETCH;
    end else if (w_load_operand && w_last_operand) begin
      w_state_nx = COMPLETE;
    end else if (w_release) begin
      w_state_nx = EMPTY;
    end

    if (!nFLUSH) begin
      w_load_opcode  = 1'b0;
      w_load_operand = 1'b0;
      w_release      = 1'b0;
      w_overrun      = 1'b0;
      w_state_nx     = EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_opcode    <= '0;
      r_operand   <= '0;
      r_instr_len <= '0;
      r_byte_cnt  <= '0;
      r_ready     <= 1'b0;
      r_ovr       <= 1'b0;
    end else if (!nFLUSH) begin
      // Flush drops the instruction but leaves opcode/operand visible.
      r_byte_cnt <= '0;
      r_ready    <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ready <= (w_state_nx == COMPLETE);
      if (w_load_opcode) begin
        r_opcode    <= WBUS;
        r_operand   <= '0;
        r_instr_len <= w_dec_len;
        r_byte_cnt  <= LEN_W'(1);
      end else if (w_load_operand) begin
        for (int s = 0; s < OPND_SLOTS; s++) begin
          if (LEN_W'(s + 1) == r_byte_cnt) begin
            r_operand[s*DATA_W +: DATA_W] <= WBUS;
          end
        end
        r_byte_cnt <= r_byte_cnt + LEN_W'(1);
      end else if (w_release) begin
        r_byte_cnt <= '0;
      end
      if (w_overrun) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign opcode    = r_opcode;
  assign operand   = r_operand;
  assign instr_len = r_instr_len;
  assign byte_cnt  = r_byte_cnt;
  assign ready     = r_ready;
  assign ovr       = r_ovr;

endmodule

// File: tb/tb_instr_fetch_register.sv
// Directed bench for instr_fetch_register: hand-computed expectations for
// single/multi-byte fetches, gaps, back-to-back, overrun, flush and async clear.
module tb_instr_fetch_register;

  localparam int DATA_W    = 8;
  localparam int MAX_BYTES = 3;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);
  localparam int OPND_W    = (MAX_BYTES - 1) * DATA_W;

  logic              clk;
  logic              clr;
  logic [DATA_W-1:0] wbus;
  logic              n_li;
  logic              n_ack;
  logic              n_flush;
  logic [DATA_W-1:0] opcode;
  logic [OPND_W-1:0] operand;
  logic [LEN_W-1:0]  instr_len;
  logic [LEN_W-1:0]  byte_cnt;
  logic              ready;
  logic              ovr;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_register #(
    .DATA_W    (DATA_W),
    .MAX_BYTES (MAX_BYTES)
  ) dut (
    .CLK       (clk),
    .CLR       (clr),
    .WBUS      (wbus),
    .nLi       (n_li),
    .nACK      (n_ack),
    .nFLUSH    (n_flush),
    .opcode    (opcode),
    .operand   (operand),
    .instr_len (instr_len),
    .byte_cnt  (byte_cnt),
    .ready     (ready),
    .ovr       (ovr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One active edge with the current inputs; returns 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DATA_W-1:0] b);
    wbus = b;
    n_li = 1'b0;
    step();
    n_li = 1'b1;
  endtask

  task automatic ack();
    n_ack = 1'b0;
    step();
    n_ack = 1'b1;
  endtask

  initial begin
    clr     = 1'b1;
    wbus    = '0;
    n_li    = 1'b1;
    n_ack   = 1'b1;
    n_flush = 1'b1;
    step();
    step();
    check("rst_opcode",  32'(opcode),    32'h00);
    check("rst_operand", 32'(operand),   32'h0000);
    check("rst_len",     32'(instr_len), 32'd0);
    check("rst_cnt",     32'(byte_cnt),  32'd0);
    check("rst_ready",   32'(ready),     32'd0);
    check("rst_ovr",     32'(ovr),       32'd0);
    clr = 1'b0;
    step();

    // ADD B: single-byte, ready right after the load edge
    load(8'h80);
    check("add_opcode",  32'(opcode),    32'h80);
    check("add_len",     32'(instr_len), 32'd1);
    check("add_cnt",     32'(byte_cnt),  32'd1);
    check("add_ready",   32'(ready),     32'd1);
    check("add_operand", 32'(operand),   32'h0000);
    ack();
    check("add_ack_ready",  32'(ready),    32'd0);
    check("add_ack_cnt",    32'(byte_cnt), 32'd0);
    check("add_ack_opcode", 32'(opcode),   32'h80);

    // MVI A,5A
    load(8'h3E);
    check("mvi_ready1",  32'(ready),     32'd0);
    check("mvi_len",     32'(instr_len), 32'd2);
    check("mvi_cnt1",    32'(byte_cnt),  32'd1);
    load(8'h5A);
    check("mvi_ready2",  32'(ready),     32'd1);
    check("mvi_operand", 32'(operand),   32'h005A);
    check("mvi_cnt2",    32'(byte_cnt),  32'd2);
    ack();

    // LDA 1234 with a gap cycle
    load(8'h3A);
    check("lda_len",     32'(instr_len), 32'd3);
    check("lda_cnt1",    32'(byte_cnt),  32'd1);
    load(8'h34);
    check("lda_cnt2",    32'(byte_cnt),  32'd2);
    check("lda_ready2",  32'(ready),     32'd0);
    step();
    check("lda_gap_cnt", 32'(byte_cnt),  32'd2);
    check("lda_gap_rdy", 32'(ready),     32'd0);
    check("lda_gap_opn", 32'(operand),   32'h0034);
    load(8'h12);
    check("lda_cnt3",    32'(byte_cnt),  32'd3);
    check("lda_ready3",  32'(ready),     32'd1);
    check("lda_operand", 32'(operand),   32'h1234);
    ack();

    // JMP 2000 then back-to-back HLT
    load(8'hC3);
    load(8'h00);
    load(8'h20);
    check("jmp_ready",   32'(ready),   32'd1);
    check("jmp_operand", 32'(operand), 32'h2000);
    wbus  = 8'h76;
    n_li  = 1'b0;
    n_ack = 1'b0;
    step();
    n_li  = 1'b1;
    n_ack = 1'b1;
    check("b2b_opcode",  32'(opcode),    32'h76);
    check("b2b_operand", 32'(operand),   32'h0000);
    check("b2b_ready",   32'(ready),     32'd1);
    check("b2b_len",     32'(instr_len), 32'd1);

    // Overrun while COMPLETE, then flush
    load(8'hFF);
    check("ovr_opcode",  32'(opcode), 32'h76);
    check("ovr_flag",    32'(ovr),    32'd1);
    check("ovr_ready",   32'(ready),  32'd1);
    step();
    check("ovr_sticky",  32'(ovr),    32'd1);
    n_flush = 1'b0;
    step();
    n_flush = 1'b1;
    check("flush_ready",  32'(ready),    32'd0);
    check("flush_ovr",    32'(ovr),      32'd0);
    check("flush_cnt",    32'(byte_cnt), 32'd0);
    check("flush_opcode", 32'(opcode),   32'h76);

    // Flushed to EMPTY: next byte is taken as an opcode; ack ignored in FETCH
    load(8'hCD);
    check("call_len",  32'(instr_len), 32'd3);
    check("call_cnt1", 32'(byte_cnt),  32'd1);
    ack();
    check("fetch_ack_cnt",   32'(byte_cnt), 32'd1);
    check("fetch_ack_ready", 32'(ready),    32'd0);
    load(8'h00);
    check("call_cnt2", 32'(byte_cnt), 32'd2);

    // Asynchronous clear mid-cycle
    #2;
    clr = 1'b1;
    #1;
    check("aclr_opcode",  32'(opcode),    32'h00);
    check("aclr_operand", 32'(operand),   32'h0000);
    check("aclr_len",     32'(instr_len), 32'd0);
    check("aclr_cnt",     32'(byte_cnt),  32'd0);
    check("aclr_ready",   32'(ready),     32'd0);
    check("aclr_ovr",     32'(ovr),       32'd0);
    @(negedge clk);
    clr = 1'b0;
    load(8'h3E);
    check("post_len",   32'(instr_len), 32'd2);
    check("post_cnt",   32'(byte_cnt),  32'd1);
    check("post_ready", 32'(ready),     32'd0);
    check("post_op",    32'(opcode),    32'h3E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
